calc_sequencer: RTL and testbench

//   Parametrised operand/operation sequencer for the calculator datapath. Collects operand A,

---
 rtl/calc_sequencer_pkg.sv | 17 +
 rtl/calc_sequencer_edge_detect.sv | 21 ++
 rtl/calc_sequencer.sv | 158 +++++++++++++++
 tb/tb_calc_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/calc_sequencer_pkg.sv
// Shared constants and state encoding for the calculator sequencer, ALU and decoder.
// Optional feature macro: CALC_CHAIN_EN (result chaining into operand A).
package calc_sequencer_pkg;

   localparam int unsigned CALC_WIDTH   = 8;
   localparam int unsigned CALC_NUM_OPS = 4;
   localparam int unsigned CALC_OP_W    = 3;

   typedef enum logic [2:0] {
      CALC_IDLE    = 3'd0,
      CALC_LOAD_A  = 3'd1,
      CALC_LOAD_B  = 3'd2,
      CALC_LOAD_OP = 3'd3,
      CALC_RESULT  = 3'd4
   } calc_state_e;

endpackage

// File: rtl/calc_sequencer_edge_detect.sv
// Rising-edge detector: pulse is high for the cycle in which sig_in first reads high.
module calc_sequencer_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic pulse
);

   logic sig_q;
   logic sig_d;

   always_comb sig_d = sig_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_q <= 1'b0;
      else        sig_q <= sig_d;
   end

   assign pulse = sig_in & ~sig_q;

endmodule

// File: rtl/calc_sequencer.sv
// Operand/op sequencer for the calculator datapath; all outputs registered.
// Define CALC_CHAIN_EN to feed the last result back as operand A on a RESULT press.
module calc_sequencer
   import calc_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH   = CALC_WIDTH,
   parameter int unsigned NUM_OPS = CALC_NUM_OPS,
   parameter int unsigned OP_W    = CALC_OP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             select,
   input  logic             restart,
   input  logic [WIDTH-1:0] value_in,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_flag,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OP_W-1:0]  alu_sel,
   output logic             alu_load,
   output logic [WIDTH-1:0] disp_value,
   output logic             disp_load,
   output logic             result_valid,
   output logic             led_flag
);

   logic press;

   calc_sequencer_edge_detect u_sel_edge (
      .clk    (clk),
      .rst_n  (rst),
      .sig_in (select),
      .pulse  (press)
   );

   calc_state_e      state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
   logic [OP_W-1:0]  sel_q, sel_d;
   logic             flag_q, flag_d, aload_q, aload_d, dload_q, dload_d, rv_q, rv_d;

   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] op_ext;
   logic             op_ok;

   always_comb begin
      op     = value_in[OP_W-1:0];
      op_ext = '0;
      op_ext[OP_W-1:0] = op;
      op_ok  = (32'(op) < NUM_OPS);
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      res_d   = res_q;
      flag_d  = flag_q;
      disp_d  = disp_q;
      aload_d = 1'b0;
      rv_d    = 1'b0;

      if (restart) begin
         state_d = CALC_IDLE;
         a_d     = '0;
         b_d     = '0;
         sel_d   = '0;
         res_d   = '0;
         flag_d  = 1'b0;
      end else begin
         unique case (state_q)
            CALC_IDLE: begin
               if (press) state_d = CALC_LOAD_A;
            end
            CALC_LOAD_A: begin
               disp_d = value_in;
               if (press) begin
                  a_d     = value_in;
                  state_d = CALC_LOAD_B;
               end
            end
            CALC_LOAD_B: begin
               disp_d = value_in;
               if (press) begin
                  b_d     = value_in;
                  state_d = CALC_LOAD_OP;
               end
            end
            CALC_LOAD_OP: begin
               disp_d = op_ext;
               // out-of-range op codes are swallowed without leaving LOAD_OP
               if (press && op_ok) begin
                  sel_d   = op;
                  aload_d = 1'b1;
                  state_d = CALC_RESULT;
               end
            end
            CALC_RESULT: begin
               disp_d = res_q;
               if (aload_q) begin
                  // capture edge; presses wait until the result is stored
                  res_d  = alu_out;
                  flag_d = alu_flag;
                  rv_d   = 1'b1;
                  disp_d = alu_out;
               end else if (press) begin
`ifdef CALC_CHAIN_EN
                  a_d     = res_q;
                  state_d = CALC_LOAD_B;
`else
                  state_d = CALC_IDLE;
`endif
               end
            end
            default: state_d = CALC_IDLE;
         endcase
      end

      dload_d = (state_d != CALC_IDLE);
      if (state_d == CALC_IDLE) disp_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CALC_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         res_q   <= '0;
         flag_q  <= 1'b0;
         disp_q  <= '0;
         aload_q <= 1'b0;
         dload_q <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         res_q   <= res_d;
         flag_q  <= flag_d;
         disp_q  <= disp_d;
         aload_q <= aload_d;
         dload_q <= dload_d;
         rv_q    <= rv_d;
      end
   end

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_sel      = sel_q;
   assign alu_load     = aload_q;
   assign disp_value   = disp_q;
   assign disp_load    = dload_q;
   assign result_valid = rv_q;
   assign led_flag     = flag_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small behavioural ALU (add/sub/and/xor).
module tb_calc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       select = 1'b0;
   logic       restart = 1'b0;
   logic [7:0] value_in = '0;
   logic [7:0] alu_out;
   logic       alu_flag;
   logic [7:0] alu_a, alu_b, disp_value;
   logic [2:0] alu_sel;
   logic       alu_load, disp_load, result_valid, led_flag;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always_comb begin
      alu_out  = '0;
      alu_flag = 1'b0;
      case (alu_sel)
         3'd0: {alu_flag, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: {alu_flag, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
         3'd2: alu_out = alu_a & alu_b;
         3'd3: alu_out = alu_a ^ alu_b;
         default: ;
      endcase
   end

   calc_sequencer #(.WIDTH(8), .NUM_OPS(4), .OP_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .select       (select),
      .restart      (restart),
      .value_in     (value_in),
      .alu_out      (alu_out),
      .alu_flag     (alu_flag),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_sel      (alu_sel),
      .alu_load     (alu_load),
      .disp_value   (disp_value),
      .disp_load    (disp_load),
      .result_valid (result_valid),
      .led_flag     (led_flag)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // called and returns on a negedge; the press is taken on the posedge in between
   task automatic press(input logic [7:0] v);
      value_in = v;
      select   = 1'b1;
      @(negedge clk);
      select = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_disp_load", disp_load, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_led", led_flag, 0);
      rst = 1'b1;
      @(negedge clk);

      // basic add 0x25 + 0x13
      press(8'h00);
      chk("loada_disp_load", disp_load, 1);
      press(8'h25);
      chk("lat_a", alu_a, 8'h25);
      press(8'h13);
      chk("lat_b", alu_b, 8'h13);
      chk("loadop_disp_zext", disp_value, 8'h03);
      value_in = 8'h00;
      select   = 1'b1;
      @(negedge clk);
      chk("alu_load_entry", alu_load, 1);
      chk("rv_early", result_valid, 0);
      select = 1'b0;
      @(negedge clk);
      chk("rv_2clk", result_valid, 1);
      chk("add_disp", disp_value, 8'h38);
      chk("add_led", led_flag, 0);
      @(negedge clk);
      chk("rv_one_cycle", result_valid, 0);
      chk("res_held", disp_value, 8'h38);
      do_restart();
      chk("restart_a", alu_a, 0);
      chk("restart_idle", disp_load, 0);

      // out-of-range op ignored
      press(8'h00);
      press(8'h3C);
      press(8'h0F);
      press(8'h05);
      chk("badop_sel", alu_sel, 0);
      chk("badop_no_load", alu_load, 0);
      chk("badop_disp", disp_value, 8'h05);
      press(8'h02);
      chk("op2_sel", alu_sel, 2);
      chk("op2_rv", result_valid, 1);
      chk("and_disp", disp_value, 8'h0C);
      do_restart();

      // restart beats a simultaneous press in LOAD_A
      press(8'h00);
      value_in = 8'h77;
      select   = 1'b1;
      restart  = 1'b1;
      @(negedge clk);
      select  = 1'b0;
      restart = 1'b0;
      @(negedge clk);
      chk("rs_press_a", alu_a, 0);
      chk("rs_press_idle", disp_load, 0);

      // carry sets led_flag, restart clears it
      press(8'h00);
      press(8'hF0);
      press(8'h20);
      press(8'h00);
      chk("carry_disp", disp_value, 8'h10);
      chk("carry_led", led_flag, 1);
      do_restart();
      chk("restart_led", led_flag, 0);
      chk("restart_res", disp_value, 0);

      // async reset mid-LOAD_B
      press(8'h00);
      press(8'h44);
      chk("pre_rst_a", alu_a, 8'h44);
      value_in = 8'h55;
      #2 rst = 1'b0;
      #1;
      chk("async_a", alu_a, 0);
      chk("async_disp", disp_value, 0);
      chk("async_dload", disp_load, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", disp_load, 0);
      press(8'h66);
      chk("post_rst_loada", disp_load, 1);
      chk("post_rst_a_clear", alu_a, 0);
      do_restart();

      // chaining 2+3, then press in RESULT
      press(8'h00);
      press(8'h02);
      press(8'h03);
      press(8'h00);
      chk("chain_first", disp_value, 8'h05);
      press(8'h04);
`ifdef CALC_CHAIN_EN
      chk("chain_a", alu_a, 8'h05);
      chk("chain_loadb", disp_load, 1);
      press(8'h04);
      press(8'h00);
      chk("chain_res", disp_value, 8'h09);
`else
      chk("nochain_idle", disp_load, 0);
      chk("nochain_a", alu_a, 8'h02);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
